// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N:1 channel selector with valid/ready handshake,
// out-of-range reporting and an auto-scan mode.
// Ports: clk, reset (async, active-high), mode (0 direct / 1 scan), sel,
//   in_data (packed channels), in_valid/in_ready (request side),
//   out_data/out_sel/out_err/out_valid/out_ready (registered result side),
//   err_cnt (8-bit saturating error count, only with MUX_SEL_ERR_CNT_EN).
module mux_sel_pipe #(
  parameter int unsigned NUM_INPUTS = 31,
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned SEL_W      = 5,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_err,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef MUX_SEL_ERR_CNT_EN
  ,
  output logic [7:0]                   err_cnt
`endif
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  scan_q, scan_d;

  logic              accept;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] pick;
  logic              hit;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx      = mode ? scan_q : sel;

  // One explicit equality decode per channel; an index with no
  // matching channel falls through to DEFAULT_VAL and flags an error.
  always_comb begin
    pick = DEFAULT_VAL;
    hit  = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (idx == SEL_W'(k)) begin
        pick = in_data[k*DATA_W +: DATA_W];
        hit  = 1'b1;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    scan_d      = scan_q;
    if (accept) begin
      out_data_d  = pick;
      out_sel_d   = idx;
      out_err_d   = !hit;
      out_valid_d = 1'b1;
      if (mode) begin
        scan_d = (scan_q == LAST_IDX) ? '0 : scan_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      scan_q      <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      scan_q      <= scan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

`ifdef MUX_SEL_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturates at 255 so a stuck bad select cannot wrap to a clean count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && !hit && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed checks of mux_sel_pipe in its default
// configuration and in a 5-channel, 8-bit parametric build.
module tb_mux_sel_pipe;

  logic        clk;
  logic        reset;

  logic        mode;
  logic [4:0]  sel;
  logic [61:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out_data;
  logic [4:0]  out_sel;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  logic        p_mode;
  logic [2:0]  p_sel;
  logic [39:0] p_in_data;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [7:0]  p_out_data;
  logic [2:0]  p_out_sel;
  logic        p_out_err;
  logic        p_out_valid;
  logic        p_out_ready;

  int total = 0;
  int bad   = 0;

  mux_sel_pipe u_dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_sel_pipe #(
    .NUM_INPUTS  (5),
    .DATA_W      (8),
    .SEL_W       (3),
    .DEFAULT_VAL (8'hA5)
  ) u_p (
    .clk       (clk),
    .reset     (reset),
    .mode      (p_mode),
    .sel       (p_sel),
    .in_data   (p_in_data),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .out_data  (p_out_data),
    .out_sel   (p_out_sel),
    .out_err   (p_out_err),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mod4();
    for (int k = 0; k < 31; k++) in_data[k*2 +: 2] = 2'(k % 4);
  endtask

  initial begin
    reset       = 1'b1;
    mode        = 1'b0;
    sel         = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_data     = '0;
    p_mode      = 1'b0;
    p_sel       = '0;
    p_in_valid  = 1'b0;
    p_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) p_in_data[k*8 +: 8] = 8'h10 + 8'(k);
    load_mod4();

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // direct sweep, one request per cycle
    in_valid = 1'b1;
    for (int s = 0; s < 31; s++) begin
      sel = 5'(s);
      step();
      chk($sformatf("dir_data%0d", s), 32'(out_data), 32'(s % 4));
      chk($sformatf("dir_sel%0d", s), 32'(out_sel), 32'(s));
      chk($sformatf("dir_err%0d", s), 32'(out_err), 32'd0);
      chk($sformatf("dir_vld%0d", s), 32'(out_valid), 32'd1);
      if (s == 12) chk("sel12", 32'(out_data), 32'd0);
      if (s == 13) chk("sel13", 32'(out_data), 32'd1);
    end

    // out-of-range select
    sel = 5'd31;
    step();
    chk("oor_data", 32'(out_data), 32'd0);
    chk("oor_sel", 32'(out_sel), 32'd31);
    chk("oor_err", 32'(out_err), 32'd1);
    chk("oor_vld", 32'(out_valid), 32'd1);

    // backpressure
    sel = 5'd5;
    step();
    chk("bp_load", 32'(out_data), 32'd1);
    out_ready = 1'b0;
    #1;
    chk("bp_inrdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sel     = 5'(7 + i);
      in_data = ~in_data;
      step();
      chk($sformatf("bp_data%0d", i), 32'(out_data), 32'd1);
      chk($sformatf("bp_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_sel%0d", i), 32'(out_sel), 32'd5);
    end
    load_mod4();
    sel       = 5'd6;
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_data", 32'(out_data), 32'd2);
    chk("bp_next_sel", 32'(out_sel), 32'd6);
    chk("bp_next_vld", 32'(out_valid), 32'd1);

    // drain with no new request: valid clears, data holds
    in_valid = 1'b0;
    step();
    chk("drain_vld", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'd2);
    chk("drain_sel", 32'(out_sel), 32'd6);

    // scan mode: pointer still 0 after direct-mode traffic
    mode     = 1'b1;
    sel      = 5'd31;
    in_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step();
      chk($sformatf("scan_sel%0d", i), 32'(out_sel), 32'(i % 31));
      chk($sformatf("scan_err%0d", i), 32'(out_err), 32'd0);
      chk($sformatf("scan_data%0d", i), 32'(out_data), 32'((i % 31) % 4));
    end

    // advance pointer to 17 (indices 2..16 issued)
    for (int i = 2; i < 17; i++) step();
    chk("pre_rst_sel", 32'(out_sel), 32'd16);
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sel", 32'(out_sel), 32'd0);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    #2;
    reset = 1'b0;
    step();
    chk("post_rst_sel", 32'(out_sel), 32'd0);
    chk("post_rst_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    mode     = 1'b0;

    // parametric build
    p_in_valid = 1'b1;
    for (int s = 4; s < 8; s++) begin
      p_sel = 3'(s);
      step();
      chk($sformatf("p_sel%0d", s), 32'(p_out_sel), 32'(s));
      chk($sformatf("p_data%0d", s), 32'(p_out_data),
          (s == 4) ? 32'h14 : 32'hA5);
      chk($sformatf("p_err%0d", s), 32'(p_out_err), (s == 4) ? 32'd0 : 32'd1);
    end
    p_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("p_scan_sel%0d", i), 32'(p_out_sel), 32'(i % 5));
      chk($sformatf("p_scan_data%0d", i), 32'(p_out_data),
          32'h10 + 32'(i % 5));
    end
    p_in_valid = 1'b0;
    step();
    chk("p_drain_vld", 32'(p_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
